instruction_fetch_unit: RTL and testbench

- Front-end stage directly upstream of the instruction register.
- Generates sequential fetch addresses and issues read requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned 19-bit instruction words, each tagged with its PC, in a small prefetch FIFO and presents them to the instruction register with valid/ready.
- The control unit redirects it on branch/jump, which flushes all buffered and in-flight instructions.

---
 rtl/instruction_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches over req/gnt/rvalid and buffers
// PC-tagged words in a prefetch FIFO. Define IFU_PERF_COUNTERS_EN for fetch/bubble counters.
module instruction_fetch_unit #(
    parameter int          WORD_SIZE  = 19,
    parameter int          ADDR_SIZE  = 19,
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr_data,
    output logic [ADDR_SIZE-1:0] instr_pc,
    input  logic                 instr_ready,
    input  logic                 redirect_valid,
    input  logic [ADDR_SIZE-1:0] redirect_addr,
    input  logic                 halt
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [15:0]          fetch_count,
    output logic [15:0]          bubble_count
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_SIZE + WORD_SIZE;
    localparam logic [CNT_W-1:0]     DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_SIZE-1:0] RESET_PC_C = ADDR_SIZE'(RESET_PC);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]     mem_d [FIFO_DEPTH];
    logic                   instr_valid_q, instr_valid_d;
    logic [WORD_SIZE-1:0]   instr_data_q, instr_data_d;
    logic [ADDR_SIZE-1:0]   instr_pc_q, instr_pc_d;
    logic                   push, pop;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mem_d         = mem_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;
        imem_req      = 1'b0;
        push          = 1'b0;
        pop           = instr_valid_q && instr_ready;

        case (state_q)
            IDLE: if (!halt && count_q < DEPTH_C) state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    fetch_pc_d = fetch_pc_q + 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT:    push = imem_rvalid;
            DISCARD: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // fetch_pc already advanced at grant, so the returning word belongs to fetch_pc-1
        if (push) begin
            mem_d[wr_ptr_q] = {fetch_pc_q - 1'b1, imem_rdata};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (state_q == WAIT && imem_rvalid)
            state_d = (!halt && count_d < DEPTH_C) ? REQ : IDLE;

        instr_valid_d = (count_d != '0);
        if (count_d != '0) {instr_pc_d, instr_data_d} = mem_d[rd_ptr_d];

        // Redirect wins over everything: flush the FIFO and retire any in-flight response
        if (redirect_valid) begin
            fetch_pc_d    = redirect_addr;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            instr_valid_d = 1'b0;
            case (state_q)
                REQ:     state_d = imem_gnt ? DISCARD : IDLE;
                WAIT:    state_d = imem_rvalid ? IDLE : DISCARD;
                DISCARD: state_d = imem_rvalid ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC_C;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

`ifdef IFU_PERF_COUNTERS_EN
    logic [15:0] fetch_count_q, fetch_count_d, bubble_count_q, bubble_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (push && !redirect_valid && fetch_count_q != 16'hFFFF)
            fetch_count_d = fetch_count_q + 16'd1;
        if (instr_ready && !instr_valid_q && bubble_count_q != 16'hFFFF)
            bubble_count_d = bubble_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding is a memory protocol error; the FSM ignores it.
    rvalid_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (state_q == WAIT || state_q == DISCARD));
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a small memory responder, a pop monitor
// and hand-computed expectations for latency, fill, redirect, wrap and halt cases.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [18:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [18:0] imem_rdata;
    logic        instr_valid;
    logic [18:0] instr_data;
    logic [18:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [18:0] redirect_addr;
    logic        halt;
`ifdef IFU_PERF_COUNTERS_EN
    logic [15:0] fetch_count;
    logic [15:0] bubble_count;
`endif

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    bit          gnt_en;
    bit          stale_en;
    int          rv_delay;
    bit          pend;
    int          pend_cnt;
    logic [18:0] pend_addr;
    logic [18:0] grant_q[$];
    logic [37:0] pop_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        grant_q.delete();
        pop_q.delete();
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] pop_at(input int i);
        if (i < pop_q.size()) return 64'(pop_q[i]);
        return 64'hDEAD_0000_0000_0000;
    endfunction

    function automatic logic [63:0] grant_at(input int i);
        if (i < grant_q.size()) return 64'(grant_q[i]);
        return 64'hDEAD_0000_0000_0000;
    endfunction

    function automatic logic [63:0] entry(input logic [18:0] pc, input logic [18:0] data);
        return 64'({pc, data});
    endfunction

    // Memory responder: grants while gnt_en, answers rv_delay cycles after each grant.
    // Word at address a is a + 0x40000 (mod 2^19) unless stale_en forces 0x7FFFF.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        pend_cnt    = 0;
        pend_addr   = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (rst_n !== 1'b1) begin
                imem_gnt = 1'b0;
                pend     = 1'b0;
            end else begin
                if (pend) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = stale_en ? 19'h7FFFF : pend_addr + 19'h40000;
                        pend        = 1'b0;
                    end
                end
                imem_gnt = gnt_en;
                if (imem_req === 1'b1 && gnt_en) begin
                    pend      = 1'b1;
                    pend_cnt  = rv_delay;
                    pend_addr = imem_addr;
                    grant_q.push_back(imem_addr);
                end
            end
        end
    end

    // Consumer monitor: records every accepted instruction just before the clock edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 && redirect_valid === 1'b0)
                pop_q.push_back({instr_pc, instr_data});
        end
    end

    initial begin
        int cnt;
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        halt           = 1'b0;
        gnt_en         = 1'b1;
        stale_en       = 1'b0;
        rv_delay       = 1;

        // Reset state, then streaming with gnt tied high and one-cycle response
        tick(2);
        check_eq("rst_req",   64'(imem_req),    64'd0);
        check_eq("rst_addr",  64'(imem_addr),   64'd0);
        check_eq("rst_valid", 64'(instr_valid), 64'd0);
        check_eq("rst_data",  64'(instr_data),  64'd0);
        check_eq("rst_pc",    64'(instr_pc),    64'd0);
        grant_q.delete();
        pop_q.delete();
        rst_n = 1'b1;
        tick(2);
        check_eq("t1_valid_c2", 64'(instr_valid), 64'd0);
        tick(1);
        check_eq("t1_valid_c3", 64'(instr_valid), 64'd1);
        check_eq("t1_pc_c3",    64'(instr_pc),    64'h0);
        check_eq("t1_data_c3",  64'(instr_data),  64'h40000);
        tick(10);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1_gaddr%0d", i), grant_at(i), 64'(i));
            check_eq($sformatf("t1_pop%0d", i), pop_at(i), entry(19'(i), 19'h40000 + 19'(i)));
        end

        // Consumer stalled: exactly four fetches, then refill after it drains
        instr_ready = 1'b0;
        do_reset();
        tick(15);
        check_eq("t2_grants",  64'(grant_q.size()), 64'd4);
        check_eq("t2_req_off", 64'(imem_req),       64'd0);
        check_eq("t2_valid",   64'(instr_valid),    64'd1);
        check_eq("t2_head",    entry(instr_pc, instr_data), entry(19'h0, 19'h40000));
        instr_ready = 1'b1;
        tick(12);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("t2_pop%0d", i), pop_at(i), entry(19'(i), 19'h40000 + 19'(i)));
        check_eq("t2_refill", 64'(grant_q.size() >= 6), 64'd1);

        // Redirect while waiting; the stale response (0x7FFFF) must be dropped
        rv_delay = 3;
        stale_en = 1'b1;
        do_reset();
        tick(2);
        check_eq("t3_in_wait", 64'(imem_req), 64'd0);
        redirect_valid = 1'b1;
        redirect_addr  = 19'h100;
        tick(1);
        redirect_valid = 1'b0;
        check_eq("t3_valid_flush", 64'(instr_valid), 64'd0);
        check_eq("t3_req_discard", 64'(imem_req),    64'd0);
        tick(2);
        rv_delay = 1;
        stale_en = 1'b0;
        tick(3);
        check_eq("t3_valid", 64'(instr_valid), 64'd1);
        check_eq("t3_pc",    64'(instr_pc),    64'h100);
        check_eq("t3_data",  64'(instr_data),  64'h40100);
        tick(4);
        check_eq("t3_gaddr0", grant_at(0), 64'h0);
        check_eq("t3_gaddr1", grant_at(1), 64'h100);
        check_eq("t3_pop0",   pop_at(0),   entry(19'h100, 19'h40100));
        cnt = 0;
        foreach (pop_q[i]) if (pop_q[i][18:0] == 19'h7FFFF) cnt++;
        check_eq("t3_stale_seen", 64'(cnt), 64'd0);

        // Redirect coinciding with pop and push while three entries are buffered
        instr_ready = 1'b0;
        do_reset();
        tick(8);
        check_eq("t4_pre_valid", 64'(instr_valid), 64'd1);
        check_eq("t4_pre_pc",    64'(instr_pc),    64'h0);
        check_eq("t4_pre_req",   64'(imem_req),    64'd0);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 19'h200;
        tick(1);
        redirect_valid = 1'b0;
        check_eq("t4_valid_flush", 64'(instr_valid), 64'd0);
        tick(10);
        check_eq("t4_gaddr4", grant_at(4), 64'h200);
        check_eq("t4_pop0",   pop_at(0),   entry(19'h200, 19'h40200));
        cnt = 0;
        foreach (pop_q[i]) if (pop_q[i][37:19] < 19'h200) cnt++;
        check_eq("t4_old_seen", 64'(cnt), 64'd0);

        // Address wrap from 0x7FFFF to 0 with back-to-back issue
        gnt_en = 1'b0;
        do_reset();
        tick(1);
        check_eq("t5_req0", 64'(imem_req), 64'd1);
        redirect_valid = 1'b1;
        redirect_addr  = 19'h7FFFF;
        tick(1);
        redirect_valid = 1'b0;
        gnt_en         = 1'b1;
        check_eq("t5_req_dropped", 64'(imem_req), 64'd0);
        tick(1);
        check_eq("t5_req_top",  64'(imem_req),  64'd1);
        check_eq("t5_addr_top", 64'(imem_addr), 64'h7FFFF);
        tick(2);
        check_eq("t5_req_wrap",  64'(imem_req),  64'd1);
        check_eq("t5_addr_wrap", 64'(imem_addr), 64'h0);
        check_eq("t5_head",      entry(instr_pc, instr_data), entry(19'h7FFFF, 19'h3FFFF));
        check_eq("t5_gaddr0",    grant_at(0), 64'h7FFFF);

        // Halt raised with a request pending and grant withheld
        gnt_en = 1'b0;
        do_reset();
        tick(1);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq($sformatf("t6_req_hold%0d", i),  64'(imem_req),  64'd1);
            check_eq($sformatf("t6_addr_hold%0d", i), 64'(imem_addr), 64'h0);
        end
`ifdef IFU_PERF_COUNTERS_EN
        check_eq("t6_bubble", 64'(bubble_count), 64'd4);
        check_eq("t6_fetch0", 64'(fetch_count),  64'd0);
`endif
        gnt_en = 1'b1;
        tick(4);
        check_eq("t6_req_after", 64'(imem_req),       64'd0);
        check_eq("t6_grants",    64'(grant_q.size()), 64'd1);
        check_eq("t6_pop0",      pop_at(0),           entry(19'h0, 19'h40000));
`ifdef IFU_PERF_COUNTERS_EN
        check_eq("t6_fetch1", 64'(fetch_count), 64'd1);
`endif
        redirect_valid = 1'b1;
        redirect_addr  = 19'h300;
        tick(1);
        redirect_valid = 1'b0;
        tick(3);
        check_eq("t6_req_halted", 64'(imem_req),       64'd0);
        check_eq("t6_grants2",    64'(grant_q.size()), 64'd1);
        halt = 1'b0;
        tick(1);
        check_eq("t6_req_resume",  64'(imem_req),  64'd1);
        check_eq("t6_addr_resume", 64'(imem_addr), 64'h300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
